// File: rtl/fifo_wr_arb.sv
// rtl/fifo_wr_arb.sv - round-robin 4-requester arbiter feeding one FIFO write port with burst-limited tenures
module fifo_wr_arb #(
  parameter int W     = 8,
  parameter int BURST = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [3:0]     iREQ,
  input  logic [4*W-1:0] iD,
  input  logic           iFULL,
  output logic [3:0]     oGNT,
  output logic           oENQ,
  output logic [W-1:0]   oD,
  output logic [1:0]     oOWNER,
  output logic           oBUSY
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] owner_q, owner_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] pick;
  logic       last_xfer;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      owner_q <= 2'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Descending scan so the requester closest to the pointer wins.
  always_comb begin
    pick = ptr_q;
    for (int j = 3; j >= 0; j--) begin
      if (iREQ[ptr_q + 2'(j)]) pick = ptr_q + 2'(j);
    end
  end

  always_comb begin
    oENQ      = (state_q == OWN) & iREQ[owner_q] & ~iFULL;
    oGNT      = oENQ ? (4'b0001 << owner_q) : 4'b0000;
    oD        = oENQ ? iD[owner_q*W +: W] : '0;
    oOWNER    = owner_q;
    oBUSY     = (state_q == OWN);
    last_xfer = oENQ && (cnt_q == 8'(BURST - 1));
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (iREQ != 4'b0000) begin
          owner_d = pick;
          cnt_d   = 8'd0;
          state_d = OWN;
        end
      end
      OWN: begin
        if (oENQ) cnt_d = cnt_q + 8'd1;
        // A stalled owner keeps the port; only a dropped request or a full burst releases it.
        if (!iREQ[owner_q] || last_xfer) begin
          state_d = IDLE;
          ptr_d   = owner_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb/tb_fifo_wr_arb.sv - self-checking bench for fifo_wr_arb at BURST 4, 2 and 1
module tb_fifo_wr_arb;
  localparam int W  = 8;
  localparam int NI = 3;

  logic           clk;
  logic           reset;
  logic [3:0]     iREQ;
  logic [4*W-1:0] iD;
  logic           iFULL;

  logic [3:0]   gnt   [NI];
  logic         enq   [NI];
  logic [W-1:0] dout  [NI];
  logic [1:0]   own_o [NI];
  logic         busy  [NI];

  int burst [NI] = '{4, 2, 1};

  fifo_wr_arb #(.W(W), .BURST(4)) u_b4 (.clk(clk), .reset(reset), .iREQ(iREQ), .iD(iD), .iFULL(iFULL),
    .oGNT(gnt[0]), .oENQ(enq[0]), .oD(dout[0]), .oOWNER(own_o[0]), .oBUSY(busy[0]));
  fifo_wr_arb #(.W(W), .BURST(2)) u_b2 (.clk(clk), .reset(reset), .iREQ(iREQ), .iD(iD), .iFULL(iFULL),
    .oGNT(gnt[1]), .oENQ(enq[1]), .oD(dout[1]), .oOWNER(own_o[1]), .oBUSY(busy[1]));
  fifo_wr_arb #(.W(W), .BURST(1)) u_b1 (.clk(clk), .reset(reset), .iREQ(iREQ), .iD(iD), .iFULL(iFULL),
    .oGNT(gnt[2]), .oENQ(enq[2]), .oD(dout[2]), .oOWNER(own_o[2]), .oBUSY(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the port, the rotating start point and transfers so far.
  bit m_own   [NI];
  int m_owner [NI];
  int m_ptr   [NI];
  int m_cnt   [NI];

  // Observation-side trackers and last sampled outputs.
  bit           pb    [NI];
  int           x_cnt [NI];
  int           wt    [NI][4];
  logic         s_enq  [NI];
  logic [W-1:0] s_d    [NI];
  logic [1:0]   s_own  [NI];
  logic         s_busy [NI];

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_own[i] = 0; m_owner[i] = 0; m_ptr[i] = 0; m_cnt[i] = 0;
      pb[i] = 0; x_cnt[i] = 0;
      for (int k = 0; k < 4; k++) wt[i][k] = 0;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if (gnt[i] !== 4'b0 || enq[i] !== 1'b0 || dout[i] !== '0 || own_o[i] !== 2'b0 || busy[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s inst%0d: gnt=%b enq=%b d=%h owner=%0d busy=%b required all zero",
                 tag, i, gnt[i], enq[i], dout[i], own_o[i], busy[i]);
      end
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic [3:0] req, input logic [4*W-1:0] d, input logic full);
    int o, c, k;
    logic e_enq;
    logic [3:0] e_gnt;
    logic [W-1:0] e_d;
    iREQ = req; iD = d; iFULL = full;
    #1;
    for (int i = 0; i < NI; i++) begin
      o     = m_owner[i];
      e_enq = m_own[i] && req[o] && !full;
      e_gnt = e_enq ? (4'b0001 << o) : 4'b0000;
      e_d   = e_enq ? d[o*W +: W] : '0;
      n_checks++;
      if (enq[i] !== e_enq) begin n_fail++; $display("FAIL enq inst%0d: got %b expected %b", i, enq[i], e_enq); end
      n_checks++;
      if (gnt[i] !== e_gnt) begin n_fail++; $display("FAIL gnt inst%0d: got %b expected %b", i, gnt[i], e_gnt); end
      n_checks++;
      if (dout[i] !== e_d) begin n_fail++; $display("FAIL data inst%0d: got %h expected %h", i, dout[i], e_d); end
      n_checks++;
      if (own_o[i] !== 2'(o)) begin n_fail++; $display("FAIL owner inst%0d: got %0d expected %0d", i, own_o[i], o); end
      n_checks++;
      if (busy[i] !== m_own[i]) begin n_fail++; $display("FAIL busy inst%0d: got %b expected %b", i, busy[i], m_own[i]); end
      n_checks++;
      if (enq[i] === 1'b1 && full) begin n_fail++; $display("FAIL enq_while_full inst%0d: got enq=1 expected 0", i); end
      n_checks++;
      if (!$onehot0(gnt[i])) begin n_fail++; $display("FAIL gnt_onehot inst%0d: got %b expected one-hot or zero", i, gnt[i]); end
      for (k = 0; k < 4; k++) if (!req[k]) wt[i][k] = 0;
      if (busy[i] && !pb[i]) begin
        x_cnt[i] = 0;
        c = int'(own_o[i]);
        n_checks++;
        if (wt[i][c] > 3) begin n_fail++; $display("FAIL fairness inst%0d req%0d: waited %0d tenures, limit 3", i, c, wt[i][c]); end
        wt[i][c] = 0;
        for (k = 0; k < 4; k++) if (k != c && req[k]) wt[i][k]++;
      end
      if (enq[i] === 1'b1) begin
        x_cnt[i]++;
        n_checks++;
        if (x_cnt[i] > burst[i]) begin n_fail++; $display("FAIL tenure_len inst%0d: got %0d transfers limit %0d", i, x_cnt[i], burst[i]); end
      end
      pb[i] = busy[i];
      s_enq[i] = enq[i]; s_d[i] = dout[i]; s_own[i] = own_o[i]; s_busy[i] = busy[i];
    end
    @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      if (!m_own[i]) begin
        if (req != 4'b0) begin
          for (k = 0; k < 4; k++) if (req[(m_ptr[i] + k) % 4]) break;
          m_owner[i] = (m_ptr[i] + k) % 4;
          m_cnt[i] = 0;
          m_own[i] = 1;
        end
      end else begin
        e_enq = req[m_owner[i]] && !full;
        if (!req[m_owner[i]] || (e_enq && m_cnt[i] == burst[i] - 1)) begin
          m_own[i] = 0;
          m_ptr[i] = (m_owner[i] + 1) % 4;
        end
        if (e_enq) m_cnt[i]++;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; iREQ = 4'b0; iFULL = 1'b0; iD = '0;
    #1;
    check_zero_outputs("reset_outputs");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    check_zero_outputs("power_on_reset");
    @(negedge clk);
    do_reset();
  endtask

  task automatic test_single();
    logic [W-1:0] val, exp;
    logic e_busy;
    do_reset();
    val = 1; exp = 1;
    for (int c = 0; c < 7; c++) begin
      step(4'b0001, {4{val}}, 1'b0);
      e_busy = (c != 0 && c != 5);
      n_checks++;
      if (s_busy[0] !== e_busy) begin n_fail++; $display("FAIL single_busy c%0d: got %b expected %b", c, s_busy[0], e_busy); end
      if (e_busy) begin
        n_checks++;
        if (s_enq[0] !== 1'b1 || s_d[0] !== exp) begin
          n_fail++; $display("FAIL single_data c%0d: got enq=%b d=%0d expected enq=1 d=%0d", c, s_enq[0], s_d[0], exp);
        end
        exp++;
      end
      if (s_enq[0] === 1'b1) val++;
    end
  endtask

  task automatic test_round_robin();
    logic e_busy;
    do_reset();
    for (int c = 0; c < 15; c++) begin
      step(4'b1111, {$urandom}, 1'b0);
      e_busy = (c % 3 != 0);
      n_checks++;
      if (s_busy[1] !== e_busy || s_enq[1] !== e_busy) begin
        n_fail++; $display("FAIL rr_busy c%0d: got busy=%b enq=%b expected %b", c, s_busy[1], s_enq[1], e_busy);
      end
      if (e_busy) begin
        n_checks++;
        if (s_own[1] !== 2'((c / 3) % 4)) begin
          n_fail++; $display("FAIL rr_owner c%0d: got %0d expected %0d", c, s_own[1], (c / 3) % 4);
        end
      end
    end
  endtask

  task automatic test_full_stall();
    logic f, e_enq, e_busy;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      f = (c >= 2 && c <= 6);
      step(4'b0100, {$urandom}, f);
      e_busy = (c >= 1 && c <= 9);
      e_enq  = e_busy && !f;
      n_checks++;
      if (s_busy[0] !== e_busy || s_enq[0] !== e_enq) begin
        n_fail++; $display("FAIL stall c%0d: got busy=%b enq=%b expected busy=%b enq=%b", c, s_busy[0], s_enq[0], e_busy, e_enq);
      end
      if (e_busy) begin
        n_checks++;
        if (s_own[0] !== 2'd2) begin n_fail++; $display("FAIL stall_owner c%0d: got %0d expected 2", c, s_own[0]); end
      end
    end
  endtask

  task automatic test_early_release();
    logic [3:0] reqs [5] = '{4'b0010, 4'b1010, 4'b1000, 4'b1001, 4'b1001};
    logic e_busy [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [1:0] e_own [5] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd3};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      step(reqs[c], {$urandom}, 1'b0);
      n_checks++;
      if (s_busy[0] !== e_busy[c] || s_own[0] !== e_own[c]) begin
        n_fail++; $display("FAIL early_release c%0d: got busy=%b owner=%0d expected busy=%b owner=%0d",
                           c, s_busy[0], s_own[0], e_busy[c], e_own[c]);
      end
    end
  endtask

  task automatic test_reset_mid_tenure();
    do_reset();
    step(4'b1000, {$urandom}, 1'b0);
    step(4'b1000, {$urandom}, 1'b0);
    iREQ = 4'b1000; iD = {$urandom};
    #1;
    n_checks++;
    if (enq[0] !== 1'b1) begin n_fail++; $display("FAIL second_xfer_setup: got enq=%b expected 1", enq[0]); end
    #1;
    reset = 1'b1;
    #1;
    check_zero_outputs("async_reset_mid_tenure");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(4'b1010, {$urandom}, 1'b0);
    step(4'b1010, {$urandom}, 1'b0);
    n_checks++;
    if (s_busy[0] !== 1'b1 || s_own[0] !== 2'd1) begin
      n_fail++; $display("FAIL post_reset_owner: got busy=%b owner=%0d expected busy=1 owner=1", s_busy[0], s_own[0]);
    end
  endtask

  task automatic test_random_stress();
    logic [3:0] r;
    do_reset();
    r = 4'($urandom);
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < 4; k++) if ($urandom_range(7) == 0) r[k] = ~r[k];
      step(r, {$urandom}, ($urandom_range(3) == 0));
    end
  endtask

  initial begin
    reset = 1'b1; iREQ = 4'b0; iD = '0; iFULL = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_early_release();
    test_reset_mid_tenure();
    test_random_stress();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
